// File: rtl/sa_gemm_driver.sv
// Memory-side driver for one systolic-array GEMM tile: loads N weight rows, feeds N
// activation/partial-sum rows, and buffers the array's N output rows in a small result FIFO.
module sa_gemm_driver #(
  parameter int N         = 4,
  parameter int DW        = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err_ovf,
  input  logic                 wt_valid,
  output logic                 wt_ready,
  input  logic [DW*N-1:0]      wt_data,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [DW*N-1:0]      act_data,
  input  logic [DW*N-1:0]      ps_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DW*N-1:0]      res_data,
  output logic [$clog2(N)-1:0] res_row,
  output logic                 weight_en,
  output logic                 input_en,
  output logic                 partial_en,
  output logic [$clog2(N)-1:0] row_in_en,
  output logic [$clog2(N)-1:0] row_ps_en,
  output logic [DW*N-1:0]      array_in,
  output logic [DW*N-1:0]      array_in_partials,
  output logic                 stall_sa,
  input  logic                 drained,
  input  logic                 fifo_has_space,
  input  logic                 out_en,
  input  logic [$clog2(N)-1:0] row_out,
  input  logic [DW*N-1:0]      array_output
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(OUT_DEPTH);
  localparam int EW = RW + DW*N;
  localparam logic [RW-1:0] LAST_ROW  = RW'(N-1);
  localparam logic [RW:0]   N_ROWS    = (RW+1)'(N);
  localparam logic [CW:0]   DEPTH     = (CW+1)'(OUT_DEPTH);
  localparam logic [CW:0]   STALL_LVL = (CW+1)'(OUT_DEPTH-2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [RW-1:0]   in_cnt_q, in_cnt_d;
  logic [RW:0]     out_cnt_q, out_cnt_d;
  logic            weight_en_q, weight_en_d;
  logic            input_en_q, input_en_d;
  logic            partial_en_q, partial_en_d;
  logic [RW-1:0]   row_in_en_q, row_in_en_d;
  logic [RW-1:0]   row_ps_en_q, row_ps_en_d;
  logic [DW*N-1:0] array_in_q, array_in_d;
  logic [DW*N-1:0] array_in_partials_q, array_in_partials_d;
  logic            stall_sa_q, stall_sa_d;
  logic            err_ovf_q, err_ovf_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW:0]     count_q, count_d;
  logic [EW-1:0]   mem_q [OUT_DEPTH];
  logic [EW-1:0]   mem_d [OUT_DEPTH];

  logic wt_hs, act_hs, push_req, push, pop, full, empty;
  logic [EW-1:0] head;

  assign wt_ready  = (state_q == S_LOAD_W) & fifo_has_space & ~stall_sa_q;
  assign act_ready = (state_q == S_FEED) & fifo_has_space & ~stall_sa_q;
  assign wt_hs     = wt_valid & wt_ready;
  assign act_hs    = act_valid & act_ready;

  // Result FIFO bookkeeping; a push onto a full FIFO is only legal when a pop frees a slot.
  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == '0);
  assign pop      = ~empty & res_ready;
  assign push_req = out_en & (state_q != S_IDLE);
  assign push     = push_req & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    err_ovf_d  = err_ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = {row_out, array_output};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_req & ~push) begin
      err_ovf_d = 1'b1;
    end
    count_d    = count_q + (CW+1)'(push) - (CW+1)'(pop);
    stall_sa_d = (count_d >= STALL_LVL);
  end

  // Tile sequencer; array-side enables default low and data buses hold their last value.
  always_comb begin
    state_d             = state_q;
    in_cnt_d            = in_cnt_q;
    out_cnt_d           = out_cnt_q;
    weight_en_d         = 1'b0;
    input_en_d          = 1'b0;
    partial_en_d        = 1'b0;
    row_in_en_d         = row_in_en_q;
    row_ps_en_d         = row_ps_en_q;
    array_in_d          = array_in_q;
    array_in_partials_d = array_in_partials_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD_W;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_LOAD_W: begin
        if (wt_hs) begin
          weight_en_d = 1'b1;
          array_in_d  = wt_data;
          row_in_en_d = in_cnt_q;
          if (in_cnt_q == LAST_ROW) begin
            state_d  = S_FEED;
            in_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      S_FEED: begin
        if (act_hs) begin
          input_en_d          = 1'b1;
          partial_en_d        = 1'b1;
          array_in_d          = act_data;
          array_in_partials_d = ps_data;
          row_in_en_d         = in_cnt_q;
          row_ps_en_d         = in_cnt_q;
          if (in_cnt_q == LAST_ROW) begin
            state_d  = S_DRAIN;
            in_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if ((out_cnt_q == N_ROWS) && drained) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Dropped rows still count so an overflowing tile terminates.
    if (push_req && (out_cnt_q != N_ROWS)) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= S_IDLE;
      in_cnt_q            <= '0;
      out_cnt_q           <= '0;
      weight_en_q         <= 1'b0;
      input_en_q          <= 1'b0;
      partial_en_q        <= 1'b0;
      row_in_en_q         <= '0;
      row_ps_en_q         <= '0;
      array_in_q          <= '0;
      array_in_partials_q <= '0;
      stall_sa_q          <= 1'b0;
      err_ovf_q           <= 1'b0;
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      count_q             <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q             <= state_d;
      in_cnt_q            <= in_cnt_d;
      out_cnt_q           <= out_cnt_d;
      weight_en_q         <= weight_en_d;
      input_en_q          <= input_en_d;
      partial_en_q        <= partial_en_d;
      row_in_en_q         <= row_in_en_d;
      row_ps_en_q         <= row_ps_en_d;
      array_in_q          <= array_in_d;
      array_in_partials_q <= array_in_partials_d;
      stall_sa_q          <= stall_sa_d;
      err_ovf_q           <= err_ovf_d;
      wr_ptr_q            <= wr_ptr_d;
      rd_ptr_q            <= rd_ptr_d;
      count_q             <= count_d;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head              = mem_q[rd_ptr_q];
  assign res_valid         = ~empty;
  assign res_data          = head[DW*N-1:0];
  assign res_row           = head[EW-1 -: RW];
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign err_ovf           = err_ovf_q;
  assign stall_sa          = stall_sa_q;
  assign weight_en         = weight_en_q;
  assign input_en          = input_en_q;
  assign partial_en        = partial_en_q;
  assign row_in_en         = row_in_en_q;
  assign row_ps_en         = row_ps_en_q;
  assign array_in          = array_in_q;
  assign array_in_partials = array_in_partials_q;

endmodule

// File: tb/tb_sa_gemm_driver.sv
// Directed self-checking bench for sa_gemm_driver: a table-driven weight-load phase plus
// hand-written sequences for feeding, backpressure, overflow and mid-tile reset.
module tb_sa_gemm_driver;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err_ovf;
  logic          wt_valid, wt_ready;
  logic [63:0]   wt_data;
  logic          act_valid, act_ready;
  logic [63:0]   act_data, ps_data;
  logic          res_valid, res_ready;
  logic [63:0]   res_data;
  logic [1:0]    res_row;
  logic          weight_en, input_en, partial_en;
  logic [1:0]    row_in_en, row_ps_en;
  logic [63:0]   array_in, array_in_partials;
  logic          stall_sa;
  logic          drained, fifo_has_space, out_en;
  logic [1:0]    row_out;
  logic [63:0]   array_output;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wv;
    logic        fhs;
    logic [63:0] wd;
    logic        e_wr;
    logic        e_ar;
    logic        e_we;
    logic [1:0]  e_row;
    logic [63:0] e_ai;
  } vec_t;

  vec_t vecs [9];

  sa_gemm_driver #(.N(N), .DW(DW), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err_ovf(err_ovf),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .ps_data(ps_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
    .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
    .row_in_en(row_in_en), .row_ps_en(row_ps_en),
    .array_in(array_in), .array_in_partials(array_in_partials),
    .stall_sa(stall_sa), .drained(drained), .fifo_has_space(fifo_has_space),
    .out_en(out_en), .row_out(row_out), .array_output(array_output)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {4{x}};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    wt_valid       = v.wv;
    fhs_drive(v.fhs);
    wt_data        = v.wd;
    #1;
    checkOutput($sformatf("v%0d_wt_ready", idx), 64'(wt_ready), 64'(v.e_wr));
    checkOutput($sformatf("v%0d_act_ready", idx), 64'(act_ready), 64'(v.e_ar));
    checkOutput($sformatf("v%0d_weight_en", idx), 64'(weight_en), 64'(v.e_we));
    checkOutput($sformatf("v%0d_row_in_en", idx), 64'(row_in_en), 64'(v.e_row));
    checkOutput($sformatf("v%0d_array_in", idx), array_in, v.e_ai);
    tick();
  endtask

  task automatic fhs_drive(input logic f);
    fifo_has_space = f;
  endtask

  task automatic startTile();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic loadWeights();
    for (int k = 0; k < N; k++) begin
      wt_valid = 1'b1;
      wt_data  = rep(16'(k + 1));
      tick();
    end
    wt_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
    tick();
    checkOutput("done_pulse_end", 64'(done), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic feedAndDrain(input logic [15:0] base);
    drained = 1'b0;
    for (int i = 0; i < N; i++) begin
      act_valid = 1'b1;
      act_data  = rep(base + 16'(i));
      ps_data   = rep(16'h00AA);
      #1;
      checkOutput("feed_act_ready", 64'(act_ready), 64'd1);
      tick();
      checkOutput("feed_input_en", 64'(input_en), 64'd1);
      checkOutput("feed_partial_en", 64'(partial_en), 64'd1);
      checkOutput("feed_row_in", 64'(row_in_en), 64'(i));
      checkOutput("feed_row_ps", 64'(row_ps_en), 64'(i));
      checkOutput("feed_array_in", array_in, rep(base + 16'(i)));
      checkOutput("feed_partials", array_in_partials, rep(16'h00AA));
    end
    act_valid = 1'b0;
    res_ready = 1'b1;
    drained   = 1'b1;
    for (int r = 0; r < N; r++) begin
      out_en       = 1'b1;
      row_out      = 2'(r);
      array_output = rep(16'h0100 + base + 16'(r));
      tick();
      if (r == 0) checkOutput("drain_input_en", 64'(input_en), 64'd0);
      checkOutput("res_valid", 64'(res_valid), 64'd1);
      checkOutput("res_row", 64'(res_row), 64'(r));
      checkOutput("res_data", res_data, rep(16'h0100 + base + 16'(r)));
      checkOutput("no_stall", 64'(stall_sa), 64'd0);
    end
    out_en = 1'b0;
    waitDone();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Weight-load vectors: three held-off cycles, four back-to-back accepts, then FEED.
    vecs[0] = '{1'b1, 1'b0, rep(16'h0009), 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
    vecs[1] = '{1'b1, 1'b0, rep(16'h0009), 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
    vecs[2] = '{1'b1, 1'b0, rep(16'h0009), 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};
    vecs[3] = '{1'b1, 1'b1, rep(16'h0001), 1'b1, 1'b0, 1'b0, 2'd0, 64'd0};
    vecs[4] = '{1'b1, 1'b1, rep(16'h0002), 1'b1, 1'b0, 1'b1, 2'd0, rep(16'h0001)};
    vecs[5] = '{1'b1, 1'b1, rep(16'h0003), 1'b1, 1'b0, 1'b1, 2'd1, rep(16'h0002)};
    vecs[6] = '{1'b1, 1'b1, rep(16'h0004), 1'b1, 1'b0, 1'b1, 2'd2, rep(16'h0003)};
    vecs[7] = '{1'b0, 1'b1, rep(16'h0005), 1'b0, 1'b1, 1'b1, 2'd3, rep(16'h0004)};
    vecs[8] = '{1'b1, 1'b1, rep(16'h0006), 1'b0, 1'b1, 1'b0, 2'd3, rep(16'h0004)};

    rst = 1'b1; start = 1'b0; wt_valid = 1'b0; wt_data = '0;
    act_valid = 1'b0; act_data = '0; ps_data = '0; res_ready = 1'b1;
    drained = 1'b0; fifo_has_space = 1'b1; out_en = 1'b0; row_out = '0; array_output = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_wt_ready", 64'(wt_ready), 64'd0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_stall", 64'(stall_sa), 64'd0);
    checkOutput("rst_err_ovf", 64'(err_ovf), 64'd0);
    checkOutput("rst_array_in", array_in, 64'd0);
    tick();

    // Tile 1: table-driven weight load, then feed and drain.
    startTile();
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);
    wt_valid = 1'b0;
    feedAndDrain(16'h0010);

    // Tile 2: results back up with res_ready low, stalling the feed.
    startTile();
    loadWeights();
    res_ready = 1'b0;
    drained   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      act_valid    = 1'b1;
      act_data     = rep(16'h0020 + 16'(i));
      out_en       = 1'b1;
      row_out      = 2'(i);
      array_output = rep(16'h0200 + 16'(i));
      tick();
    end
    out_en   = 1'b0;
    act_data = rep(16'h0022);
    #1;
    checkOutput("stall_high", 64'(stall_sa), 64'd1);
    checkOutput("stall_act_ready", 64'(act_ready), 64'd0);
    checkOutput("stall_head_row", 64'(res_row), 64'd0);
    tick();
    checkOutput("stall_no_input", 64'(input_en), 64'd0);
    res_ready = 1'b1;
    tick();
    checkOutput("stall_released", 64'(stall_sa), 64'd0);
    checkOutput("pop_order_row1", 64'(res_row), 64'd1);
    checkOutput("pop_order_data1", res_data, rep(16'h0201));
    checkOutput("resume_act_ready", 64'(act_ready), 64'd1);
    tick();
    checkOutput("resume_input_en", 64'(input_en), 64'd1);
    checkOutput("resume_row2", 64'(row_in_en), 64'd2);
    checkOutput("fifo_empty", 64'(res_valid), 64'd0);
    act_data = rep(16'h0023);
    tick();
    checkOutput("resume_row3", 64'(row_in_en), 64'd3);
    checkOutput("resume_data3", array_in, rep(16'h0023));
    act_valid = 1'b0;
    drained   = 1'b1;
    for (int r = 2; r < N; r++) begin
      out_en       = 1'b1;
      row_out      = 2'(r);
      array_output = rep(16'h0200 + 16'(r));
      tick();
    end
    out_en = 1'b0;
    waitDone();

    // Tile 3: five captures into a four-deep FIFO with no drain.
    res_ready = 1'b0;
    drained   = 1'b0;
    startTile();
    loadWeights();
    for (int i = 0; i < N; i++) begin
      act_valid = 1'b1;
      act_data  = rep(16'h0030 + 16'(i));
      tick();
    end
    act_valid = 1'b0;
    for (int p = 0; p < 5; p++) begin
      out_en       = 1'b1;
      row_out      = 2'(p);
      array_output = rep(16'h0300 + 16'(p));
      tick();
    end
    out_en = 1'b0;
    checkOutput("ovf_err", 64'(err_ovf), 64'd1);
    checkOutput("ovf_stall", 64'(stall_sa), 64'd1);
    drained = 1'b1;
    waitDone();
    res_ready = 1'b1;
    #1;
    for (int p = 0; p < OD; p++) begin
      checkOutput("ovf_res_valid", 64'(res_valid), 64'd1);
      checkOutput("ovf_res_row", 64'(res_row), 64'(p));
      checkOutput("ovf_res_data", res_data, rep(16'h0300 + 16'(p)));
      tick();
    end
    checkOutput("ovf_fifo_empty", 64'(res_valid), 64'd0);
    checkOutput("ovf_sticky", 64'(err_ovf), 64'd1);

    // Tile 4: reset lands mid-feed, then a clean tile runs.
    res_ready = 1'b0;
    drained   = 1'b0;
    startTile();
    loadWeights();
    for (int i = 0; i < 2; i++) begin
      act_valid    = 1'b1;
      act_data     = rep(16'h0040 + 16'(i));
      out_en       = (i == 0);
      row_out      = 2'd0;
      array_output = rep(16'h0400);
      tick();
    end
    act_valid = 1'b0;
    out_en    = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_input_en", 64'(input_en), 64'd0);
    checkOutput("arst_partial_en", 64'(partial_en), 64'd0);
    checkOutput("arst_weight_en", 64'(weight_en), 64'd0);
    checkOutput("arst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("arst_err_ovf", 64'(err_ovf), 64'd0);
    checkOutput("arst_stall", 64'(stall_sa), 64'd0);
    checkOutput("arst_array_in", array_in, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    startTile();
    loadWeights();
    feedAndDrain(16'h0050);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sa_gemm_driver.md
Name: sa_gemm_driver

Overview:
- Memory-side driver for one systolic-array GEMM tile; the counterpart of the array on the systolic array interface.
- Accepts weight rows and activation/partial-sum rows from upstream valid/ready streams, then sequences N weight loads and N input/partial feeds into the array.
- Captures N output rows into a small result FIFO and presents them downstream on a valid/ready stream.
- Generates stall_sa as backpressure toward the array.

Parameters:
- N, 4, array dimension (rows per tile); power of 2, ≥2
- DW, 16, element width in bits
- OUT_DEPTH, 4, result FIFO depth in rows; ≥4, power of 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin tile; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when tile complete
- err_ovf  out  1  sticky result overflow; cleared only by rst
- wt_valid / wt_ready  in / out  1 / 1  weight row handshake
- wt_data  in  DW*N  weight row
- act_valid / act_ready  in / out  1 / 1  activation row handshake
- act_data  in  DW*N  activation row
- ps_data  in  DW*N  partial-sum row; qualified with act_valid
- res_valid / res_ready  out / in  1 / 1  result row handshake
- res_data  out  DW*N  result row
- res_row  out  clog2(N)  row index of res_data
- weight_en, input_en, partial_en  out  1 each  array enables
- row_in_en, row_ps_en  out  clog2(N) each  target row
- array_in, array_in_partials  out  DW*N each  array data
- stall_sa  out  1  stall array
- drained, fifo_has_space, out_en  in  1 each  array status
- row_out  in  clog2(N)  array output row index
- array_output  in  DW*N  array output data

Behaviour:
- Reset (async): state=IDLE. All outputs 0: busy, done, wt_ready, act_ready, res_valid, enables, row indices, data buses, stall_sa. Counters 0, result FIFO empty, err_ovf=0.
- Reset mid-tile aborts immediately. No partial state survives.
- States: IDLE, LOAD_W, FEED, DRAIN, DONE.
  - IDLE: start=1 → LOAD_W, in_cnt=0, out_cnt=0. start is ignored in all other states.
  - LOAD_W: wt_ready = fifo_has_space & ~stall_sa. On handshake, next cycle: weight_en=1, array_in=wt_data, row_in_en=in_cnt; in_cnt++. After the N-th accept → FEED, in_cnt=0.
  - FEED: act_ready = fifo_has_space & ~stall_sa. On handshake, next cycle: input_en=1, partial_en=1, array_in=act_data, array_in_partials=ps_data, row_in_en=row_ps_en=in_cnt; in_cnt++. After the N-th accept → DRAIN.
  - DRAIN: wait until out_cnt==N and drained==1 → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Enable and data outputs toward the array are registered: one-cycle latency from the upstream handshake.
- Enables are 0 in every cycle without a handshake. Data buses hold their last value.
- wt_ready=0 outside LOAD_W; act_ready=0 outside FEED.
- Capture, in every non-IDLE state: when out_en=1, push {row_out, array_output} into the result FIFO and increment out_cnt (saturates at N). out_en in IDLE is ignored.
- Overflow: out_en while the FIFO is full → row dropped, err_ovf set, out_cnt still increments so the tile terminates.
- Result FIFO:
  - Standard first-word-fall-through. res_valid = ~empty; res_data/res_row = head entry.
  - Pop on res_valid & res_ready.
  - Simultaneous push and pop while full is legal: count unchanged, no overflow.
  - Pointers wrap modulo OUT_DEPTH.
- stall_sa is registered and equals (FIFO count after this cycle ≥ OUT_DEPTH-2). This leaves two slots for in-flight array outputs.
- While stall_sa=1, no new rows are accepted.
- fifo_has_space=0 holds off acceptance only; rows already issued are unaffected.

Test Plan:
- N=4, DW=16, res_ready=1. Start, stream 4 weight rows 0x0001..0x0004 back-to-back. Require weight_en high 4 consecutive cycles, each one cycle after its handshake, with row_in_en=0,1,2,3. Then state FEED.
- Feed 4 activation rows with ps_data=0x00AA_replicated. Require input_en=partial_en=1 and row_in_en=row_ps_en=0..3. Model out_en for rows 0..3 with drained=1. Require 4 results with res_row=0..3, then done one-cycle pulse, busy=0.
- res_ready=0 during capture. After 2 rows captured, require stall_sa=1 and act_ready=0. Release res_ready: rows pop in order, stall_sa drops when count<2.
- Force 5 out_en pulses with res_ready=0 (OUT_DEPTH=4). Require err_ovf=1, FIFO holds the first 4 rows, tile still reaches done.
- fifo_has_space=0 in LOAD_W with wt_valid=1 for 3 cycles. Require wt_ready=0, weight_en=0. On raise, acceptance resumes at row_in_en=0.
- Assert rst in FEED after 2 rows. Require busy=0, all enables 0, res_valid=0, err_ovf=0 asynchronously. A new start then runs a full tile correctly.
